dice_game_ctrl: RTL and testbench
=================================

// Module: dice_game_ctrl
// PURPOSE
//  Two-player score keeper fed by the electronic dice. Shares button with dice;
//  takes the settled throw when button is released, validates it, adds it to
//  the current player's score, manages turns and flags the winner. Output drives
//  the display/LED stage.
// PARAMETERS
//  TARGET   default 20  score at/above which current player wins (1..2**SCORE_W-1)
//  SCORE_W  default 8   width of each score register
// PORTS
//  clk          in   1        system clock, all logic on rising edge
//  reset        in   1        synchronous, active-high
//  button       in   1        roll button, same net as dice.button (1 = rolling)
//  throw        in   3        dice output, valid values 1..6
//  player       out  1        player whose turn it is (0/1)
//  score0       out  SCORE_W  player 0 score
//  score1       out  SCORE_W  player 1 score
//  last_throw   out  3        last accepted throw
//  roll_done    out  1        1-cycle pulse when a throw is scored
//  bad_throw    out  1        1-cycle pulse when a throw of 0 or 7 is rejected
//  game_over    out  1        high from win until reset
//  winner       out  1        winning player, valid while game_over=1
// BEHAVIOUR
//  - Reset (sync, active-high, overrides everything): state=IDLE, player=0,
//    score0=score1=0, last_throw=0, roll_done=bad_throw=game_over=winner=0.
//  - FSM states: IDLE, ROLLING, SCORE, WIN.
//    IDLE:    button=1 -> ROLLING.
//    ROLLING: button=0 sampled -> capture throw into cap_reg, -> SCORE.
//             button=1 -> stay ROLLING (any duration, incl. 1 cycle).
//    SCORE:   one cycle, ignores button; evaluates cap_reg:
//             cap in 0 or 7: bad_throw=1; scores, player, last_throw unchanged; -> IDLE.
//             cap in 1..6: last_throw<=cap, roll_done=1, add cap to current player's
//               score, saturating at 2**SCORE_W-1 (no wrap);
//               new score >= TARGET -> game_over=1, winner=player, -> WIN;
//               else cap==6 -> same player again; else player toggles; -> IDLE.
//    WIN:     terminal; button/throw ignored; all outputs hold until reset.
//  - Latency: button sampled low at edge N -> scores/last_throw/roll_done updated
//    at edge N+1. A new roll needs button high again via IDLE (no double count).
//  - Button high while in SCORE is seen in IDLE on the next edge -> ROLLING.
//  - Reset mid-roll (ROLLING/SCORE) discards the captured throw entirely.
//  - roll_done and bad_throw never both high; each high exactly one cycle.
//  - Win check uses post-update score; winning on a 6 does not grant extra turn.
// CONFIGURATION
//  BUST_ON_ONE_EN defined: accepted throw of 1 clears current player's score to
//    0 (no add, no win check), roll_done=1, last_throw=1, turn passes.
//  BUST_ON_ONE_EN undefined: 1 scored like any other value (+1).
// TESTING
//  1. Reset 5 cycles -> all outputs 0; player=0; state IDLE.
//  2. P0 rolls, release with throw=3 -> 1 cycle after: score0=3, last_throw=3,
//     roll_done pulse, player=1.
//  3. P1 throw=6 -> score1=6, player stays 1; next throw=2 -> score1=8, player=0.
//  4. throw=7 at release -> bad_throw pulse, no roll_done, scores/player unchanged.
//  5. score0=17, throw=4 -> score0=21, game_over=1, winner=0; further rolls
//     ignored; reset -> all 0. With SCORE_W=4, TARGET=15: 13+5 -> score saturates 15.
//  6. BUST_ON_ONE_EN: score0=9, throw=1 -> score0=0, player=1; undefined -> 10.

Source files
------------

// File: rtl/dice_game_ctrl.sv
// dice_game_ctrl
//   Two-player score keeper for the electronic dice. It picks up the settled
//   throw when the shared roll button is released, rejects the invalid codes
//   0 and 7, adds valid throws to the current player's score with saturation,
//   manages the turn order and latches the winner.
//
// Parameters
//   TARGET   score at or above which the current player wins (1..2**SCORE_W-1)
//   SCORE_W  width of each score register (>= 3)
//
// Optional feature macro
//   BUST_ON_ONE_EN  when defined, an accepted throw of 1 clears the current
//                   player's score and passes the turn instead of adding 1.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high
//   button      in   roll button (1 = dice rolling)
//   throw       in   dice value, valid 1..6
//   player      out  player whose turn it is
//   score0/1    out  player scores
//   last_throw  out  last accepted throw
//   roll_done   out  one-cycle pulse when a throw is scored
//   bad_throw   out  one-cycle pulse when a throw of 0 or 7 is rejected
//   game_over   out  high from the win until reset
//   winner      out  winning player, valid while game_over is high
//
// state   | meaning
// IDLE    | waiting for the button to be pressed
// ROLLING | button held, dice rolling; release captures the throw
// SCORE   | one cycle evaluating the captured throw
// WIN     | terminal, everything frozen until reset
module dice_game_ctrl #(
  parameter int TARGET  = 20,
  parameter int SCORE_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               button,
  input  logic [2:0]         throw,
  output logic               player,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic [2:0]         last_throw,
  output logic               roll_done,
  output logic               bad_throw,
  output logic               game_over,
  output logic               winner
);

  typedef enum logic [1:0] {IDLE, ROLLING, SCORE, WIN} state_t;

  localparam logic [SCORE_W-1:0] TGT = SCORE_W'(TARGET);

  state_t             state;
  logic [2:0]         cap_reg;
  logic [SCORE_W-1:0] cur_score;
  logic [SCORE_W:0]   sum;
  logic [SCORE_W-1:0] new_score;
  logic               wins;

  // One extra sum bit catches overflow so the score pins at all-ones.
  always_comb begin
    cur_score = player ? score1 : score0;
    sum       = {1'b0, cur_score} + {{(SCORE_W-2){1'b0}}, cap_reg};
    new_score = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    wins      = (new_score >= TGT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cap_reg    <= 3'd0;
      player     <= 1'b0;
      score0     <= '0;
      score1     <= '0;
      last_throw <= 3'd0;
      roll_done  <= 1'b0;
      bad_throw  <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 1'b0;
    end else begin
      roll_done <= 1'b0;
      bad_throw <= 1'b0;
      case (state)
        IDLE: begin
          if (button) state <= ROLLING;
        end
        ROLLING: begin
          if (!button) begin
            cap_reg <= throw;
            state   <= SCORE;
          end
        end
        SCORE: begin
          state <= IDLE;
          if (cap_reg == 3'd0 || cap_reg == 3'd7) begin
            bad_throw <= 1'b1;
          end else begin
            last_throw <= cap_reg;
            roll_done  <= 1'b1;
`ifdef BUST_ON_ONE_EN
            if (cap_reg == 3'd1) begin
              if (player) score1 <= '0;
              else        score0 <= '0;
              player <= ~player;
            end else
`endif
            begin
              if (player) score1 <= new_score;
              else        score0 <= new_score;
              if (wins) begin
                game_over <= 1'b1;
                winner    <= player;
                state     <= WIN;
              end else if (cap_reg != 3'd6) begin
                player <= ~player;
              end
            end
          end
        end
        WIN: begin
          state <= WIN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dice_game_ctrl.sv
module tb_dice_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       button = 1'b0;
  logic [2:0] throw = 3'd0;

  logic       player, roll_done, bad_throw, game_over, winner;
  logic [7:0] score0, score1;
  logic [2:0] last_throw;

  logic       b_player, b_roll_done, b_bad_throw, b_game_over, b_winner;
  logic [3:0] b_score0, b_score1;
  logic [2:0] b_last_throw;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dice_game_ctrl #(.TARGET(20), .SCORE_W(8)) dut (
    .clk(clk), .reset(reset), .button(button), .throw(throw),
    .player(player), .score0(score0), .score1(score1),
    .last_throw(last_throw), .roll_done(roll_done), .bad_throw(bad_throw),
    .game_over(game_over), .winner(winner)
  );

  dice_game_ctrl #(.TARGET(15), .SCORE_W(4)) dut_b (
    .clk(clk), .reset(reset), .button(button), .throw(throw),
    .player(b_player), .score0(b_score0), .score1(b_score1),
    .last_throw(b_last_throw), .roll_done(b_roll_done), .bad_throw(b_bad_throw),
    .game_over(b_game_over), .winner(b_winner)
  );

  task automatic do_reset(input int n);
    @(negedge clk) reset = 1'b1; button = 1'b0; throw = 3'd0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  // Press, hold for extra cycles, release with v; ends one negedge after the
  // scoring edge.
  task automatic roll(input logic [2:0] v, input int hold);
    @(negedge clk) button = 1'b1;
    repeat (hold) @(negedge clk);
    @(negedge clk) button = 1'b0; throw = v;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset(5);
    checks++; if (player !== 1'b0) begin errors++; $display("FAIL reset_player got=%b exp=0", player); end
    checks++; if (score0 !== 8'd0) begin errors++; $display("FAIL reset_score0 got=%0d exp=0", score0); end
    checks++; if (score1 !== 8'd0) begin errors++; $display("FAIL reset_score1 got=%0d exp=0", score1); end
    checks++; if (last_throw !== 3'd0) begin errors++; $display("FAIL reset_last got=%0d exp=0", last_throw); end
    checks++; if ({roll_done, bad_throw, game_over, winner} !== 4'b0) begin errors++;
      $display("FAIL reset_flags got=%b exp=0000", {roll_done, bad_throw, game_over, winner}); end
  endtask

  task automatic test_roll;
    roll(3'd3, 2);
    checks++; if (score0 !== 8'd3) begin errors++; $display("FAIL roll_score0 got=%0d exp=3", score0); end
    checks++; if (last_throw !== 3'd3) begin errors++; $display("FAIL roll_last got=%0d exp=3", last_throw); end
    checks++; if (roll_done !== 1'b1 || bad_throw !== 1'b0) begin errors++;
      $display("FAIL roll_pulse got=%b%b exp=10", roll_done, bad_throw); end
    checks++; if (player !== 1'b1) begin errors++; $display("FAIL roll_player got=%b exp=1", player); end
    @(negedge clk);
    checks++; if (roll_done !== 1'b0) begin errors++; $display("FAIL roll_pulse_width got=%b exp=0", roll_done); end
  endtask

  task automatic test_six_and_latency;
    @(negedge clk) button = 1'b1;
    @(negedge clk) button = 1'b0; throw = 3'd6;
    @(negedge clk);
    checks++; if (score1 !== 8'd0 || roll_done !== 1'b0) begin errors++;
      $display("FAIL latency_early got=%0d/%b exp=0/0", score1, roll_done); end
    @(negedge clk);
    checks++; if (score1 !== 8'd6 || roll_done !== 1'b1) begin errors++;
      $display("FAIL six_score1 got=%0d/%b exp=6/1", score1, roll_done); end
    checks++; if (player !== 1'b1) begin errors++; $display("FAIL six_extra_turn got=%b exp=1", player); end
    roll(3'd2, 1);
    checks++; if (score1 !== 8'd8 || player !== 1'b0) begin errors++;
      $display("FAIL after_six got=%0d/%b exp=8/0", score1, player); end
  endtask

  task automatic test_bad_throw;
    roll(3'd7, 3);
    checks++; if (bad_throw !== 1'b1 || roll_done !== 1'b0) begin errors++;
      $display("FAIL bad7_pulse got=%b%b exp=10", bad_throw, roll_done); end
    checks++; if (score0 !== 8'd3 || score1 !== 8'd8 || player !== 1'b0 || last_throw !== 3'd2) begin errors++;
      $display("FAIL bad7_hold got=%0d/%0d/%b/%0d exp=3/8/0/2", score0, score1, player, last_throw); end
    @(negedge clk);
    checks++; if (bad_throw !== 1'b0) begin errors++; $display("FAIL bad_pulse_width got=%b exp=0", bad_throw); end
    roll(3'd0, 0);
    checks++; if (bad_throw !== 1'b1 || score0 !== 8'd3 || player !== 1'b0) begin errors++;
      $display("FAIL bad0 got=%b/%0d/%b exp=1/3/0", bad_throw, score0, player); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk) button = 1'b1;
    @(negedge clk) button = 1'b0; throw = 3'd4;
    @(negedge clk) button = 1'b1;           // pressed during SCORE
    @(negedge clk);
    checks++; if (score0 !== 8'd7 || player !== 1'b1 || roll_done !== 1'b1) begin errors++;
      $display("FAIL b2b_first got=%0d/%b/%b exp=7/1/1", score0, player, roll_done); end
    @(negedge clk) button = 1'b0; throw = 3'd5;
    @(negedge clk);
    @(negedge clk);
    checks++; if (score1 !== 8'd13 || player !== 1'b0 || roll_done !== 1'b1) begin errors++;
      $display("FAIL b2b_second got=%0d/%b/%b exp=13/0/1", score1, player, roll_done); end
    checks++; if (score0 !== 8'd7) begin errors++; $display("FAIL b2b_no_double got=%0d exp=7", score0); end
  endtask

  task automatic test_reset_mid_roll;
    @(negedge clk) button = 1'b1;
    @(negedge clk) button = 1'b0; throw = 3'd5;
    @(negedge clk) reset = 1'b1;             // captured, in SCORE
    @(negedge clk) reset = 1'b0;
    checks++; if (score0 !== 8'd0 || roll_done !== 1'b0 || last_throw !== 3'd0 || score1 !== 8'd0) begin errors++;
      $display("FAIL midroll_reset got=%0d/%b/%0d exp=0/0/0", score0, roll_done, last_throw); end
    roll(3'd2, 0);
    checks++; if (score0 !== 8'd2 || player !== 1'b1) begin errors++;
      $display("FAIL midroll_after got=%0d/%b exp=2/1", score0, player); end
  endtask

  task automatic test_win;
    do_reset(2);
    roll(3'd6, 0); roll(3'd6, 0); roll(3'd5, 0); roll(3'd2, 0);
    checks++; if (score0 !== 8'd17 || score1 !== 8'd2 || player !== 1'b0 || game_over !== 1'b0) begin errors++;
      $display("FAIL win_setup got=%0d/%0d/%b/%b exp=17/2/0/0", score0, score1, player, game_over); end
    roll(3'd4, 1);
    checks++; if (score0 !== 8'd21 || game_over !== 1'b1 || winner !== 1'b0 || roll_done !== 1'b1) begin errors++;
      $display("FAIL win got=%0d/%b/%b/%b exp=21/1/0/1", score0, game_over, winner, roll_done); end
    roll(3'd3, 0);
    checks++; if (score0 !== 8'd21 || score1 !== 8'd2 || game_over !== 1'b1 || roll_done !== 1'b0 || last_throw !== 3'd4) begin errors++;
      $display("FAIL win_hold got=%0d/%0d/%b/%b/%0d exp=21/2/1/0/4", score0, score1, game_over, roll_done, last_throw); end
    do_reset(1);
    checks++; if (score0 !== 8'd0 || game_over !== 1'b0 || winner !== 1'b0 || player !== 1'b0) begin errors++;
      $display("FAIL win_reset got=%0d/%b/%b/%b exp=0/0/0/0", score0, game_over, winner, player); end
  endtask

  task automatic test_saturate;
    do_reset(2);
    roll(3'd4, 0); roll(3'd2, 0); roll(3'd6, 0); roll(3'd3, 0); roll(3'd2, 0);
    checks++; if (b_score0 !== 4'd13 || b_score1 !== 4'd4 || b_player !== 1'b0) begin errors++;
      $display("FAIL sat_setup got=%0d/%0d/%b exp=13/4/0", b_score0, b_score1, b_player); end
    roll(3'd5, 0);
    checks++; if (b_score0 !== 4'd15 || b_game_over !== 1'b1 || b_winner !== 1'b0) begin errors++;
      $display("FAIL sat_win got=%0d/%b/%b exp=15/1/0", b_score0, b_game_over, b_winner); end
    checks++; if (score0 !== 8'd18 || score1 !== 8'd4 || game_over !== 1'b0 || player !== 1'b1) begin errors++;
      $display("FAIL sat_wide got=%0d/%0d/%b/%b exp=18/4/0/1", score0, score1, game_over, player); end
  endtask

  task automatic test_bust;
    logic [7:0] exp_s0;
`ifdef BUST_ON_ONE_EN
    exp_s0 = 8'd0;
`else
    exp_s0 = 8'd10;
`endif
    do_reset(2);
    roll(3'd6, 0); roll(3'd3, 0); roll(3'd2, 0);
    roll(3'd1, 0);
    checks++; if (score0 !== exp_s0 || player !== 1'b1) begin errors++;
      $display("FAIL bust got=%0d/%b exp=%0d/1", score0, player, exp_s0); end
    checks++; if (roll_done !== 1'b1 || last_throw !== 3'd1) begin errors++;
      $display("FAIL bust_pulse got=%b/%0d exp=1/1", roll_done, last_throw); end
  endtask

  initial begin
    test_reset();
    test_roll();
    test_six_and_latency();
    test_bad_throw();
    test_back_to_back();
    test_reset_mid_roll();
    test_win();
    test_saturate();
    test_bust();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
